td_lock_ctrl: RTL and testbench
===============================

// Module: td_lock_ctrl
// PURPOSE
//  Bring-up/lock sequencer for the TV decoder front end. Holds the decoder in reset, launches
//  I2C configuration, waits for the HS-domain stable flag (iTD_STABLE) to qualify, then enables
//  capture aligned to a VS rising edge. Monitors loss of lock, retries failed bring-ups and
//  reports a terminal failure. Sits between TD stable detect, I2C config and the capture path.
// PARAMETERS
//  RST_HOLD_CYC   50000     cycles oTD_RESET_N held low (1 ms @ 50 MHz)
//  CFG_TIMEOUT    5000000   max cycles waiting for iCFG_DONE
//  STB_TIMEOUT    25000000  max cycles from WSTB entry to qualification
//  QUAL_CYC       5000000   consecutive stable cycles required to qualify
//  LOSS_CYC       250000    consecutive unstable cycles in LOCK that mean lock is lost
//  MAX_RETRY      7         failed attempts before FAIL (1..15)
// PORTS
//  iCLK         in   1  system clock (50 MHz)
//  iRST         in   1  synchronous, active-high reset
//  iTD_STABLE   in   1  stable flag from TD detect; asynchronous to iCLK
//  iTD_VS       in   1  decoder VS; asynchronous to iCLK
//  iCFG_DONE    in   1  I2C config complete level (iCLK domain)
//  iREINIT      in   1  1-cycle request: restart bring-up from scratch
//  oTD_RESET_N  out  1  decoder hard reset, active low
//  oCFG_START   out  1  1-cycle pulse starting I2C configuration
//  oCAP_EN      out  1  capture enable, rises only at frame start
//  oLOCKED      out  1  high while in LOCK
//  oFAIL        out  1  high while in FAIL
//  oLOST        out  1  1-cycle pulse when LOCK is lost
//  oSTATE       out  3  current state encoding
//  oRETRY       out  4  failed attempts since last lock/reinit
// BEHAVIOUR
//  - iTD_STABLE, iTD_VS pass through 2-flop synchronizers (stb_s, vs_s); vs_rise = vs_s & ~vs_d.
//  - Reset: state=RST, timers=0, oRETRY=0, oTD_RESET_N=0, all other outputs 0. All outputs registered.
//  - States: RST=0 CFG=1 WCFG=2 WSTB=3 QUAL=4 ARM=5 LOCK=6 FAIL=7.
//  - RST: oTD_RESET_N=0; after RST_HOLD_CYC cycles -> CFG. oTD_RESET_N=1 in every other state except FAIL.
//  - CFG: oCFG_START=1 for exactly this one cycle -> WCFG.
//  - WCFG: iCFG_DONE=1 -> WSTB (timer cleared); timer reaching CFG_TIMEOUT -> failure path.
//  - WSTB: stb_s=1 -> QUAL; timer (not cleared by QUAL bounce) reaching STB_TIMEOUT -> failure path.
//  - QUAL: qual counter counts consecutive stb_s=1; stb_s=0 -> WSTB, qual counter=0, timer keeps
//    running; count reaching QUAL_CYC -> ARM. STB timeout also applies in QUAL.
//  - ARM: first vs_rise -> LOCK; stb_s=0 -> WSTB. No timeout in ARM beyond STB_TIMEOUT.
//  - LOCK: oCAP_EN=1, oLOCKED=1 from first LOCK cycle; oRETRY cleared on entry. Loss counter
//    counts consecutive stb_s=0; any stb_s=1 clears it; reaching LOSS_CYC -> RST, oLOST=1 for
//    one cycle, oCAP_EN/oLOCKED low the same cycle. Loss does not increment oRETRY.
//  - Failure path: if oRETRY+1 == MAX_RETRY -> FAIL, else oRETRY+=1 and -> RST.
//  - FAIL: terminal; oFAIL=1, oTD_RESET_N=0, oRETRY=MAX_RETRY. Left only by iRST or iREINIT.
//  - iREINIT (any state, incl. FAIL): next cycle state=RST, all timers and oRETRY=0, oCAP_EN=0;
//    has priority over every other transition. iRST has priority over iREINIT.
//  - Timers: 25-bit saturating up-counters, cleared on every state change; compare with ==.
//  - iCFG_DONE already high when entering WCFG -> WSTB on the next cycle (no edge required).
// STRUCTURE
//  - Package td_ctrl_pkg: state localparams (3-bit encoding above), timer width TMR_W=25.
//  - One sub-module: td_sync2 (2-flop synchronizer, 1 bit), instanced for iTD_STABLE and iTD_VS.
//  - FSM, timer, qual/loss counters and output registers in td_lock_ctrl.
// TESTING  (params: RST_HOLD=4 CFG_TO=16 STB_TO=32 QUAL=8 LOSS=4 MAX_RETRY=2)
//  - Nominal: CFG_DONE 3 cyc after pulse, STABLE held, VS toggling -> one oCFG_START, LOCK, oCAP_EN rises 1 cyc after sync'd VS edge.
//  - Config timeout: iCFG_DONE never set -> oRETRY 0->1, second RST/CFG, then FAIL, oFAIL=1, oTD_RESET_N=0.
//  - Qual bounce: STABLE high 5 cyc, low 1, high 8 -> QUAL->WSTB->QUAL->ARM; no timeout at STB_TO=32.
//  - Loss: in LOCK drop STABLE 3 cyc -> stays LOCK; drop 4 cyc -> oLOST pulse, oCAP_EN=0, state=RST, oRETRY=0.
//  - iREINIT in FAIL and mid-QUAL -> state=RST next cycle, oRETRY=0, oFAIL=0.
//  - iRST asserted in LOCK together with iREINIT -> reset values next cycle, oTD_RESET_N=0.

Source files
------------

// File: rtl/td_ctrl_pkg.sv
// td_ctrl_pkg: state encoding and counter width shared by the TV decoder lock sequencer
package td_ctrl_pkg;
  localparam int TMR_W = 25;
  typedef enum logic [2:0] {
    ST_RST  = 3'd0,
    ST_CFG  = 3'd1,
    ST_WCFG = 3'd2,
    ST_WSTB = 3'd3,
    ST_QUAL = 3'd4,
    ST_ARM  = 3'd5,
    ST_LOCK = 3'd6,
    ST_FAIL = 3'd7
  } state_t;
  function automatic logic in_stb_phase(input state_t s);
    return s inside {ST_WSTB, ST_QUAL, ST_ARM};
  endfunction
endpackage

// File: rtl/td_sync2.sv
// td_sync2: two-flop synchronizer bringing one asynchronous bit into the clk domain
module td_sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic [1:0] sync_q, sync_d;
  // shift the raw input through two stages
  always_comb sync_d = {sync_q[0], d};
  // stages clear on reset so the first samples read as low
  always_ff @(posedge clk) sync_q <= rst ? 2'b00 : sync_d;
  assign q = sync_q[1];
endmodule

// File: rtl/td_lock_ctrl.sv
// td_lock_ctrl: TV decoder bring-up, qualification, VS-aligned capture enable and lock-loss sequencer
module td_lock_ctrl
  import td_ctrl_pkg::*;
#(
  parameter int RST_HOLD_CYC = 50000,
  parameter int CFG_TIMEOUT  = 5000000,
  parameter int STB_TIMEOUT  = 25000000,
  parameter int QUAL_CYC     = 5000000,
  parameter int LOSS_CYC     = 250000,
  parameter int MAX_RETRY    = 7
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iTD_STABLE,
  input  logic       iTD_VS,
  input  logic       iCFG_DONE,
  input  logic       iREINIT,
  output logic       oTD_RESET_N,
  output logic       oCFG_START,
  output logic       oCAP_EN,
  output logic       oLOCKED,
  output logic       oFAIL,
  output logic       oLOST,
  output logic [2:0] oSTATE,
  output logic [3:0] oRETRY
);
  localparam logic [TMR_W-1:0] RST_LIM  = TMR_W'(RST_HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] CFG_LIM  = TMR_W'(CFG_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] STB_LIM  = TMR_W'(STB_TIMEOUT - 1);
  localparam logic [TMR_W-1:0] QUAL_LIM = TMR_W'(QUAL_CYC);
  localparam logic [TMR_W-1:0] LOSS_LIM = TMR_W'(LOSS_CYC);
  localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

  logic stb_s, vs_s, vs_rise, fail_path;
  state_t state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d, qcnt_q, qcnt_d, lcnt_q, lcnt_d;
  logic [3:0] retry_q, retry_d;
  logic vs_dly_q, vs_dly_d;
  logic rst_n_q, rst_n_d, cfg_start_q, cfg_start_d, cap_en_q, cap_en_d;
  logic locked_q, locked_d, fail_q, fail_d, lost_q, lost_d;

  td_sync2 u_stb_sync (.clk(iCLK), .rst(iRST), .d(iTD_STABLE), .q(stb_s));
  td_sync2 u_vs_sync  (.clk(iCLK), .rst(iRST), .d(iTD_VS),     .q(vs_s));

  assign vs_rise = vs_s & ~vs_dly_q;

  // next-state, counter and output decode; the stable-wait timer spans WSTB/QUAL/ARM
  always_comb begin
    state_d   = state_q;
    retry_d   = retry_q;
    qcnt_d    = '0;
    lcnt_d    = '0;
    lost_d    = 1'b0;
    fail_path = 1'b0;
    vs_dly_d  = vs_s;
    case (state_q)
      ST_RST:  if (tmr_q == RST_LIM) state_d = ST_CFG;
      ST_CFG:  state_d = ST_WCFG;
      ST_WCFG: if (iCFG_DONE) state_d = ST_WSTB;
               else if (tmr_q == CFG_LIM) fail_path = 1'b1;
      ST_WSTB: if (tmr_q == STB_LIM) fail_path = 1'b1;
               else if (stb_s) begin
                 state_d = ST_QUAL;
                 qcnt_d  = TMR_W'(1);
               end
      ST_QUAL: if (tmr_q == STB_LIM) fail_path = 1'b1;
               else if (!stb_s) state_d = ST_WSTB;
               else if (qcnt_q + 1'b1 == QUAL_LIM) state_d = ST_ARM;
               else qcnt_d = qcnt_q + 1'b1;
      ST_ARM:  if (tmr_q == STB_LIM) fail_path = 1'b1;
               else if (!stb_s) state_d = ST_WSTB;
               else if (vs_rise) begin
                 state_d = ST_LOCK;
                 retry_d = '0;
               end
      ST_LOCK: if (!stb_s) begin
                 if (lcnt_q + 1'b1 == LOSS_LIM) begin
                   state_d = ST_RST;
                   lost_d  = 1'b1;
                 end else lcnt_d = lcnt_q + 1'b1;
               end
      ST_FAIL: state_d = ST_FAIL;
      default: state_d = ST_RST;
    endcase
    if (fail_path) begin
      retry_d = retry_q + 4'd1;
      state_d = (retry_q + 4'd1 == RETRY_LIM) ? ST_FAIL : ST_RST;
    end
    if (iREINIT) begin
      state_d = ST_RST;
      retry_d = '0;
      qcnt_d  = '0;
      lcnt_d  = '0;
      lost_d  = 1'b0;
    end
    tmr_d = (iREINIT || (state_d != state_q && !(in_stb_phase(state_d) && in_stb_phase(state_q)))) ? '0 :
            (&tmr_q ? tmr_q : tmr_q + 1'b1);
    rst_n_d     = !(state_d inside {ST_RST, ST_FAIL});
    cfg_start_d = state_d == ST_CFG;
    cap_en_d    = state_d == ST_LOCK;
    locked_d    = state_d == ST_LOCK;
    fail_d      = state_d == ST_FAIL;
  end

  // single register bank for FSM state, counters and every output
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q     <= ST_RST;
      tmr_q       <= '0;
      qcnt_q      <= '0;
      lcnt_q      <= '0;
      retry_q     <= '0;
      vs_dly_q    <= 1'b0;
      rst_n_q     <= 1'b0;
      cfg_start_q <= 1'b0;
      cap_en_q    <= 1'b0;
      locked_q    <= 1'b0;
      fail_q      <= 1'b0;
      lost_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      qcnt_q      <= qcnt_d;
      lcnt_q      <= lcnt_d;
      retry_q     <= retry_d;
      vs_dly_q    <= vs_dly_d;
      rst_n_q     <= rst_n_d;
      cfg_start_q <= cfg_start_d;
      cap_en_q    <= cap_en_d;
      locked_q    <= locked_d;
      fail_q      <= fail_d;
      lost_q      <= lost_d;
    end
  end

  assign oTD_RESET_N = rst_n_q;
  assign oCFG_START  = cfg_start_q;
  assign oCAP_EN     = cap_en_q;
  assign oLOCKED     = locked_q;
  assign oFAIL       = fail_q;
  assign oLOST       = lost_q;
  assign oSTATE      = state_q;
  assign oRETRY      = retry_q;
endmodule

// File: tb/tb_td_lock_ctrl.sv
// tb_td_lock_ctrl: directed and randomized checks of td_lock_ctrl against a behavioural model
module tb_td_lock_ctrl;
  localparam int RST_HOLD = 4, CFG_TO = 16, STB_TO = 32, QUAL = 8, LOSS = 4, MAXR = 2;
  localparam int S_RST = 0, S_CFG = 1, S_WCFG = 2, S_WSTB = 3, S_QUAL = 4, S_ARM = 5, S_LOCK = 6, S_FAIL = 7;

  logic clk = 1'b0, rst = 1'b1, stable = 1'b0, vs = 1'b0, cfg_done = 1'b0, reinit = 1'b0;
  logic rst_n, cfg_start, cap_en, locked, fail, lost;
  logic [2:0] state;
  logic [3:0] retry;

  int checks = 0, errors = 0;
  int m_st = 0, m_age = 0, m_win = 0, m_run = 0, m_bad = 0, m_retry = 0;
  bit m_lost, m_s1, m_s2, m_v1, m_v2, m_v3;
  int vs_cnt = 0, vs_per = 6, n_cfg = 0;
  bit saw_q, bounce;
  int flip [4] = '{1, 2, 8, 30};

  td_lock_ctrl #(
    .RST_HOLD_CYC(RST_HOLD), .CFG_TIMEOUT(CFG_TO), .STB_TIMEOUT(STB_TO),
    .QUAL_CYC(QUAL), .LOSS_CYC(LOSS), .MAX_RETRY(MAXR)
  ) dut (
    .iCLK(clk), .iRST(rst), .iTD_STABLE(stable), .iTD_VS(vs), .iCFG_DONE(cfg_done), .iREINIT(reinit),
    .oTD_RESET_N(rst_n), .oCFG_START(cfg_start), .oCAP_EN(cap_en), .oLOCKED(locked),
    .oFAIL(fail), .oLOST(lost), .oSTATE(state), .oRETRY(retry)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic go(input int s);
    m_st = s; m_age = 0; m_run = 0; m_bad = 0;
  endtask

  task automatic give_up();
    m_retry++;
    go(m_retry == MAXR ? S_FAIL : S_RST);
  endtask

  task automatic model_step();
    bit stb, rise;
    stb = m_s2;
    rise = m_v2 & !m_v3;
    m_lost = 1'b0;
    if (rst) begin
      go(S_RST); m_win = 0; m_retry = 0;
      {m_s1, m_s2, m_v1, m_v2, m_v3} = '0;
      return;
    end
    m_s2 = m_s1; m_s1 = stable;
    m_v3 = m_v2; m_v2 = m_v1; m_v1 = vs;
    if (reinit) begin
      go(S_RST); m_win = 0; m_retry = 0;
      return;
    end
    m_age++;
    if (m_st inside {S_WSTB, S_QUAL, S_ARM}) m_win++;
    case (m_st)
      S_RST:  if (m_age == RST_HOLD) go(S_CFG);
      S_CFG:  go(S_WCFG);
      S_WCFG: if (cfg_done) begin go(S_WSTB); m_win = 0; end
              else if (m_age == CFG_TO) give_up();
      S_WSTB, S_QUAL, S_ARM:
        if (m_win == STB_TO) give_up();
        else if (m_st == S_WSTB) begin
          if (stb) begin go(S_QUAL); m_run = 1; end
        end
        else if (!stb) go(S_WSTB);
        else if (m_st == S_QUAL) begin
          m_run++;
          if (m_run == QUAL) go(S_ARM);
        end
        else if (rise) begin go(S_LOCK); m_retry = 0; end
      S_LOCK: if (stb) m_bad = 0;
              else begin
                m_bad++;
                if (m_bad == LOSS) begin go(S_RST); m_lost = 1'b1; end
              end
      default: ;
    endcase
  endtask

  task automatic tick();
    logic [5:0] ev;
    @(posedge clk);
    model_step();
    #1;
    ev = {m_st != S_RST && m_st != S_FAIL, m_st == S_CFG, m_st == S_LOCK, m_st == S_LOCK, m_st == S_FAIL, m_lost};
    chk("state", 32'(state), 32'(m_st));
    chk("retry", 32'(retry), 32'(m_retry));
    chk("outs", 32'({rst_n, cfg_start, cap_en, locked, fail, lost}), 32'(ev));
    if (cfg_start) n_cfg++;
    if (state == 3'(S_QUAL)) saw_q = 1'b1;
    if (saw_q && state == 3'(S_WSTB)) bounce = 1'b1;
    vs_cnt++;
    vs = (vs_cnt % vs_per) < vs_per / 2;
  endtask

  initial begin
    repeat (3) tick();
    chk("rst_state", 32'(state), S_RST);
    chk("rst_resetn", 32'(rst_n), 0);
    chk("rst_retry", 32'(retry), 0);

    rst = 1'b0; stable = 1'b1; n_cfg = 0;
    for (int i = 0; i < 20 && cfg_start !== 1'b1; i++) tick();
    chk("nom_cfg_pulse", 32'(cfg_start), 1);
    repeat (3) tick();
    cfg_done = 1'b1;
    for (int i = 0; i < 100 && locked !== 1'b1; i++) tick();
    chk("nom_locked", 32'(locked), 1);
    chk("nom_cap_en", 32'(cap_en), 1);
    chk("nom_cfg_count", 32'(n_cfg), 1);

    stable = 1'b0;
    repeat (3) tick();
    stable = 1'b1;
    repeat (4) tick();
    chk("loss_short_state", 32'(state), S_LOCK);
    stable = 1'b0;
    for (int i = 0; i < 10 && lost !== 1'b1; i++) tick();
    chk("loss_pulse", 32'(lost), 1);
    chk("loss_cap_en", 32'(cap_en), 0);
    chk("loss_state", 32'(state), S_RST);
    chk("loss_retry", 32'(retry), 0);
    stable = 1'b1;

    cfg_done = 1'b0; reinit = 1'b1;
    tick();
    reinit = 1'b0; n_cfg = 0;
    for (int i = 0; i < 100 && fail !== 1'b1; i++) tick();
    chk("cto_fail", 32'(fail), 1);
    chk("cto_resetn", 32'(rst_n), 0);
    chk("cto_retry", 32'(retry), MAXR);
    chk("cto_state", 32'(state), S_FAIL);
    chk("cto_cfg_count", 32'(n_cfg), 2);

    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    chk("reinit_fail_state", 32'(state), S_RST);
    chk("reinit_fail_retry", 32'(retry), 0);
    chk("reinit_fail_flag", 32'(fail), 0);

    cfg_done = 1'b1; stable = 1'b0;
    for (int i = 0; i < 20 && state !== 3'(S_WSTB); i++) tick();
    chk("bounce_wstb", 32'(state), S_WSTB);
    saw_q = 1'b0; bounce = 1'b0; stable = 1'b1;
    repeat (5) tick();
    stable = 1'b0;
    tick();
    stable = 1'b1;
    for (int i = 0; i < 40 && state !== 3'(S_ARM); i++) tick();
    chk("bounce_arm", 32'(state), S_ARM);
    chk("bounce_seen", 32'(bounce), 1);
    chk("bounce_retry", 32'(retry), 0);

    cfg_done = 1'b0; reinit = 1'b1;
    tick();
    reinit = 1'b0;
    for (int i = 0; i < 60 && retry !== 4'd1; i++) tick();
    chk("midq_retry1", 32'(retry), 1);
    cfg_done = 1'b1;
    for (int i = 0; i < 60 && state !== 3'(S_QUAL); i++) tick();
    chk("midq_in_qual", 32'(state), S_QUAL);
    repeat (2) tick();
    reinit = 1'b1;
    tick();
    reinit = 1'b0;
    chk("midq_state", 32'(state), S_RST);
    chk("midq_retry", 32'(retry), 0);
    chk("midq_fail", 32'(fail), 0);

    for (int i = 0; i < 200 && locked !== 1'b1; i++) tick();
    chk("rr_locked", 32'(locked), 1);
    rst = 1'b1; reinit = 1'b1;
    tick();
    rst = 1'b0; reinit = 1'b0;
    chk("rr_state", 32'(state), S_RST);
    chk("rr_resetn", 32'(rst_n), 0);
    chk("rr_locked_low", 32'(locked), 0);
    chk("rr_retry", 32'(retry), 0);

    for (int seg = 0; seg < 4; seg++) begin
      vs_per = $urandom_range(4, 12);
      stable = 1'b1;
      for (int i = 0; i < 600; i++) begin
        if ($urandom_range(0, 99) < flip[seg]) stable = ~stable;
        cfg_done = ($urandom_range(0, 3) == 0);
        reinit = ($urandom_range(0, 149) == 0);
        tick();
      end
    end
    reinit = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
